// File: rtl/nibble_alu_sequencer.sv
// Execution stage for the 4x4 Register_File: two reads over the single read
// port, one ALU operation, then a write-back framed by a clean active-low strobe.
module nibble_alu_sequencer #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic [ADDR_W-1:0] dst,
  output logic [ADDR_W-1:0] rf_read_add,
  output logic              rf_read_en,
  input  logic [DATA_W-1:0] rf_data_out,
  output logic [ADDR_W-1:0] rf_write_add,
  output logic              rf_write_en,
  output logic [DATA_W-1:0] rf_data_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  typedef enum logic [2:0] {
    IDLE, RDA, RDB, EXEC, WSETUP, WSTROBE, WHOLD
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rd_add_q, rd_add_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   wr_add_q, wr_add_d;
  logic                wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                carry_q, carry_d;
  logic                zero_q, zero_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   src_b_q;
  logic [ADDR_W-1:0]   dst_q;
  logic [DATA_W-1:0]   opa_q;
  logic [DATA_W-1:0]   opb_q;
  logic [DATA_W:0]     alu_res;

  // MSB is the carry-out for ADD and the borrow (a<b) for SUB.
  function automatic logic [DATA_W:0] alu_f(input logic [1:0]        f,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic [DATA_W:0] r;
    case (f)
      2'b00:   r = {1'b0, a} + {1'b0, b};
      2'b01:   r = {(a < b), a - b};
      2'b10:   r = {1'b0, a & b};
      default: r = {1'b0, a ^ b};
    endcase
    return r;
  endfunction

  assign alu_res = alu_f(op_q, opa_q, opb_q);

  always_comb begin
    state_d  = state_q;
    rd_add_d = rd_add_q;
    rd_en_d  = rd_en_q;
    wr_add_d = wr_add_q;
    wr_en_d  = wr_en_q;
    wdata_d  = wdata_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          rd_add_d = src_a;
          rd_en_d  = 1'b0;
          busy_d   = 1'b1;
          state_d  = RDA;
        end
      end
      RDA: begin
        rd_add_d = src_b_q;
        state_d  = RDB;
      end
      RDB: begin
        rd_en_d = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        result_d = alu_res[DATA_W-1:0];
        carry_d  = alu_res[DATA_W];
        zero_d   = (alu_res[DATA_W-1:0] == '0);
        wr_add_d = dst_q;
        wdata_d  = alu_res[DATA_W-1:0];
        wr_en_d  = 1'b1;
        state_d  = WSETUP;
      end
      WSETUP: begin
        wr_en_d = 1'b0;
        state_d = WSTROBE;
      end
      WSTROBE: begin
        wr_en_d = 1'b1;
        done_d  = 1'b1;
        state_d = WHOLD;
      end
      WHOLD: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Async reset also forces the write strobe high, cutting any strobe short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rd_add_q <= '0;
      rd_en_q  <= 1'b1;
      wr_add_q <= '0;
      wr_en_q  <= 1'b1;
      wdata_q  <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_add_q <= rd_add_d;
      rd_en_q  <= rd_en_d;
      wr_add_q <= wr_add_d;
      wr_en_q  <= wr_en_d;
      wdata_q  <= wdata_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Command fields and operands; only written in the states that own them.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      op_q    <= op;
      src_b_q <= src_b;
      dst_q   <= dst;
    end
    if (state_q == RDA) opa_q <= rf_data_out;
    if (state_q == RDB) opb_q <= rf_data_out;
  end

  assign rf_read_add  = rd_add_q;
  assign rf_read_en   = rd_en_q;
  assign rf_write_add = wr_add_q;
  assign rf_write_en  = wr_en_q;
  assign rf_data_in   = wdata_q;
  assign result       = result_q;
  assign carry        = carry_q;
  assign zero         = zero_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_nibble_alu_sequencer.sv
// Scoreboard bench for nibble_alu_sequencer with a behavioural 4x4 register file.
module tb_nibble_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [1:0] src_a = '0, src_b = '0, dst = '0;
  logic [1:0] rf_read_add, rf_write_add;
  logic       rf_read_en, rf_write_en;
  logic [3:0] rf_data_out, rf_data_in, result;
  logic       busy, done, carry, zero;

  nibble_alu_sequencer #(.DATA_W(4), .ADDR_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .dst(dst),
    .rf_read_add(rf_read_add), .rf_read_en(rf_read_en), .rf_data_out(rf_data_out),
    .rf_write_add(rf_write_add), .rf_write_en(rf_write_en), .rf_data_in(rf_data_in),
    .busy(busy), .done(done), .result(result), .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  // Register file model: write on the clock edge while the strobe is low.
  logic [3:0] mem [4];
  logic       pre_we = 1'b0;
  logic [1:0] pre_addr = '0;
  logic [3:0] pre_data = '0;
  always @(posedge clk) begin
    if (!rf_write_en) mem[rf_write_add] <= rf_data_in;
    else if (pre_we)  mem[pre_addr]     <= pre_data;
  end
  assign rf_data_out = mem[rf_read_add];

  typedef struct {
    logic [3:0] res;
    logic       c;
    logic       z;
    logic [1:0] d;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int strobe_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Monitor: read/write exclusion every cycle; score each done pulse.
  always @(negedge clk) begin
    exp_t e;
    check("rd_wr_exclusive", int'(!rf_read_en && !rf_write_en), 0);
    if (!rst_n) strobe_cnt = 0;
    else begin
      if (!rf_write_en) strobe_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("result",       int'(result),       int'(e.res));
          check("carry",        int'(carry),        int'(e.c));
          check("zero",         int'(zero),         int'(e.z));
          check("rf_write_add", int'(rf_write_add), int'(e.d));
          check("rf_data_in",   int'(rf_data_in),   int'(e.res));
          check("rf_mem_dst",   int'(mem[e.d]),     int'(e.res));
          check("done_latency", cyc - e.cyc,        6);
          check("strobe_len",   strobe_cnt,         1);
          check("busy_in_done", int'(busy),         1);
        end
        strobe_cnt = 0;
      end
    end
  end

  task automatic preload(input logic [1:0] a, input logic [3:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || sb.size() != 0) && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) check("idle_timeout", 1, 0);
  endtask

  task automatic issue(input logic [1:0] f, input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] d, input logic [3:0] r, input logic c,
                       input logic z);
    exp_t e;
    @(negedge clk);
    wait_idle();
    start = 1'b1; op = f; src_a = a; src_b = b; dst = d;
    e.res = r; e.c = c; e.z = z; e.d = d; e.cyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    exp_t e;
    repeat (2) @(posedge clk);
    #1;
    check("rst_read_en",  int'(rf_read_en),   1);
    check("rst_write_en", int'(rf_write_en),  1);
    check("rst_read_add", int'(rf_read_add),  0);
    check("rst_write_add",int'(rf_write_add), 0);
    check("rst_data_in",  int'(rf_data_in),   0);
    check("rst_result",   int'(result),       0);
    check("rst_flags",    int'({carry, zero, busy, done}), 0);

    preload(2'd0, 4'b0001);
    preload(2'd1, 4'b0010);
    preload(2'd2, 4'b0100);
    preload(2'd3, 4'b1000);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD 1+2 -> R2
    issue(2'b00, 2'd0, 2'd1, 2'd2, 4'b0011, 1'b0, 1'b0);
    @(negedge clk); wait_idle();
    // ADD 9+8 overflows -> R3 = 1, carry
    preload(2'd0, 4'b1001);
    preload(2'd1, 4'b1000);
    issue(2'b00, 2'd0, 2'd1, 2'd3, 4'b0001, 1'b1, 1'b0);
    // SUB R1-R1 -> R0 = 0
    issue(2'b01, 2'd1, 2'd1, 2'd0, 4'b0000, 1'b0, 1'b1);
    @(negedge clk); wait_idle();
    // SUB 1-4 borrows -> R1 = 1101
    preload(2'd0, 4'b0001);
    preload(2'd2, 4'b0100);
    issue(2'b01, 2'd0, 2'd2, 2'd1, 4'b1101, 1'b1, 1'b0);
    // AND 1101 & 0100 -> R2 = 0100
    issue(2'b10, 2'd1, 2'd2, 2'd2, 4'b0100, 1'b0, 1'b0);

    // XOR R3^R3 -> R3 = 0, with start pulses in cycles 2 and 4 to be ignored
    @(negedge clk); wait_idle();
    start = 1'b1; op = 2'b11; src_a = 2'd3; src_b = 2'd3; dst = 2'd3;
    e.res = 4'b0000; e.c = 1'b0; e.z = 1'b1; e.d = 2'd3; e.cyc = cyc;
    sb.push_back(e);
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; op = 2'b00; src_a = 2'd0; src_b = 2'd1; dst = 2'd0;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); wait_idle();
    repeat (10) @(negedge clk);
    check("ignored_start_r0", int'(mem[0]), 1);
    check("ignored_start_busy", int'(busy), 0);

    // Reset during the write strobe of ADD 0,1 -> 3; R3 must stay 0
    start = 1'b1; op = 2'b00; src_a = 2'd0; src_b = 2'd1; dst = 2'd3;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (rf_write_en && k < 20) begin @(negedge clk); k++; end
    check("strobe_seen", int'(rf_write_en), 0);
    #1 rst_n = 1'b0;
    #1;
    check("abort_write_en", int'(rf_write_en), 1);
    check("abort_busy",     int'(busy),        0);
    check("abort_done",     int'(done),        0);
    check("abort_read_en",  int'(rf_read_en),  1);
    repeat (2) @(negedge clk);
    check("abort_r3_kept",  int'(mem[3]),      0);
    rst_n = 1'b1;
    // ADD 1+13 -> R2 = 14 after reset
    issue(2'b00, 2'd0, 2'd1, 2'd2, 4'b1110, 1'b0, 1'b0);
    @(negedge clk); wait_idle();
    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
